// File: rtl/icache_fill.sv
// rtl/icache_fill.sv - icache miss fill: byte-serial 32-bit fetch into one cache line slot
// Optional ICACHE_FILL_COMPRESSED_EN adds compressed-instruction detection and second-half (pc+2) fields.
module icache_fill (
    input  logic        clk,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        fill_req,
    input  logic [31:0] fill_pc,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_a,
    output logic        mem_rd_en,
    input  logic [7:0]  mem_din,
    output logic        update,
    output logic [31:0] mem2cache_inst,
    output logic [3:0]  mem2cache_idx,
    output logic [26:0] mem2cache_tag,
    output logic [31:0] mem2cache_PC,
    output logic        is_c_inst,
    output logic [31:0] sec_inst_addr,
    output logic [3:0]  sec_inst_index,
    output logic [26:0] sec_inst_tag,
    output logic        fill_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_pc_lat;
    logic [23:0] r_data;
    logic [31:0] r_inst;
    logic [31:0] r_pc_out;
    logic        w_accept;
    logic [31:0] w_word;

    assign w_accept = (r_state == S_IDLE) && fill_req && mem_gnt && !flush_in;
    // Byte 3 arrives in the same cycle the word is published, so it bypasses r_data.
    assign w_word   = {mem_din, r_data};

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_pc_lat <= 32'd0;
            r_data   <= 24'd0;
            r_inst   <= 32'd0;
            r_pc_out <= 32'd0;
        end else if (rdy_in) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_READ;
                        r_pc_lat <= fill_pc;
                        r_cnt    <= 3'd0;
                    end
                end
                S_READ: begin
                    if (flush_in) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_cnt != 3'd4) begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                        case (r_cnt)
                            3'd1: r_data[7:0]   <= mem_din;
                            3'd2: r_data[15:8]  <= mem_din;
                            3'd3: r_data[23:16] <= mem_din;
                            3'd4: begin
                                r_state  <= S_DONE;
                                r_inst   <= w_word;
                                r_pc_out <= r_pc_lat;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fill_busy      = (r_state != S_IDLE);
    assign mem_req        = rst_n_in && (((r_state == S_IDLE) && fill_req && !flush_in) || (r_state == S_READ));
    assign mem_rd_en      = (r_state == S_READ) && rdy_in && (r_cnt != 3'd4);
    assign mem_a          = (r_state == S_READ) ? (r_pc_lat + {29'd0, r_cnt}) : 32'd0;
    assign update         = (r_state == S_DONE) && rdy_in;
    assign mem2cache_inst = r_inst;
    assign mem2cache_PC   = r_pc_out;
    assign mem2cache_idx  = r_pc_out[4:1];
    assign mem2cache_tag  = r_pc_out[31:5];

`ifdef ICACHE_FILL_COMPRESSED_EN
    logic        r_is_c;
    logic [31:0] r_sec_addr;

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_is_c     <= 1'b0;
            r_sec_addr <= 32'd0;
        end else if (rdy_in && (r_state == S_READ) && !flush_in && (r_cnt == 3'd4)) begin
            r_is_c     <= (w_word[1:0] != 2'b11);
            r_sec_addr <= r_pc_lat + 32'd2;
        end
    end

    assign is_c_inst      = r_is_c;
    assign sec_inst_addr  = r_sec_addr;
    assign sec_inst_index = r_sec_addr[4:1];
    assign sec_inst_tag   = r_sec_addr[31:5];
`else
    assign is_c_inst      = 1'b0;
    assign sec_inst_addr  = 32'd0;
    assign sec_inst_index = 4'd0;
    assign sec_inst_tag   = 27'd0;
`endif

endmodule

// File: tb/tb_icache_fill.sv
// tb/tb_icache_fill.sv - randomized self-checking bench for icache_fill against a byte-memory reference model
module tb_icache_fill;

    logic        clk = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic        fill_req;
    logic [31:0] fill_pc;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_a;
    logic        mem_rd_en;
    logic [7:0]  mem_din = 8'd0;
    logic        update;
    logic [31:0] mem2cache_inst;
    logic [3:0]  mem2cache_idx;
    logic [26:0] mem2cache_tag;
    logic [31:0] mem2cache_PC;
    logic        is_c_inst;
    logic [31:0] sec_inst_addr;
    logic [3:0]  sec_inst_index;
    logic [26:0] sec_inst_tag;
    logic        fill_busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] mem_ovr [logic [31:0]];

    icache_fill dut (
        .clk(clk), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .fill_req(fill_req), .fill_pc(fill_pc), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_a(mem_a), .mem_rd_en(mem_rd_en), .mem_din(mem_din), .update(update),
        .mem2cache_inst(mem2cache_inst), .mem2cache_idx(mem2cache_idx),
        .mem2cache_tag(mem2cache_tag), .mem2cache_PC(mem2cache_PC),
        .is_c_inst(is_c_inst), .sec_inst_addr(sec_inst_addr),
        .sec_inst_index(sec_inst_index), .sec_inst_tag(sec_inst_tag), .fill_busy(fill_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5a;
    endfunction

    // One-cycle-latency byte memory: data for the address read in cycle t shows up in cycle t+1.
    always @(posedge clk) begin
        if (mem_rd_en) mem_din <= mem_byte(mem_a);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_fill(input logic [31:0] pc, input int gnt_wait, input int stall_at,
                            input int stall_len, input int flush_at);
        logic [31:0] exp_word;
        logic [31:0] exp_sec;
        logic        exp_c;
        int n, st;
        bit finished, aborted;
        exp_word = {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
`ifdef ICACHE_FILL_COMPRESSED_EN
        exp_c   = (exp_word[1:0] != 2'b11);
        exp_sec = pc + 32'd2;
`else
        exp_c   = 1'b0;
        exp_sec = 32'd0;
`endif
        @(negedge clk);
        rdy_in = 1'b1; flush_in = 1'b0; fill_req = 1'b1; fill_pc = pc; mem_gnt = 1'b0;
        for (int i = 0; i < gnt_wait; i++) begin
            #1;
            chk("wait_mem_req", mem_req, 1);
            chk("wait_rd_en", mem_rd_en, 0);
            chk("wait_busy", fill_busy, 0);
            @(negedge clk);
        end
        mem_gnt = 1'b1;
        #1 chk("gnt_mem_req", mem_req, 1);
        @(negedge clk);
        fill_req = 1'b0; mem_gnt = 1'b0;
        n = 0; st = 0; finished = 0; aborted = 0;
        for (int cyc = 0; cyc < 20 && !finished; cyc++) begin
            if (n == stall_at && st < stall_len) begin
                rdy_in = 1'b0; flush_in = 1'b0;
                #1;
                chk("stall_busy", fill_busy, 1);
                chk("stall_rd_en", mem_rd_en, 0);
                chk("stall_update", update, 0);
                if (n <= 3) chk("stall_mem_a", mem_a, pc + n);
                st++;
            end else begin
                rdy_in = 1'b1; flush_in = (n == flush_at);
                #1;
                chk("busy", fill_busy, 1);
                if (n <= 4) begin
                    chk("rd_en", mem_rd_en, (n <= 3));
                    chk("update_early", update, 0);
                end
                if (n <= 3) chk("mem_a", mem_a, pc + n);
                if (n == 5) begin
                    chk("update", update, 1);
                    chk("inst", mem2cache_inst, exp_word);
                    chk("pc", mem2cache_PC, pc);
                    chk("idx", mem2cache_idx, pc[4:1]);
                    chk("tag", mem2cache_tag, pc[31:5]);
                    chk("is_c", is_c_inst, exp_c);
                    chk("sec_addr", sec_inst_addr, exp_sec);
                    chk("sec_idx", sec_inst_index, exp_sec[4:1]);
                    chk("sec_tag", sec_inst_tag, exp_sec[31:5]);
                    finished = 1;
                end
                if (n == flush_at && n <= 4) begin
                    aborted = 1;
                    finished = 1;
                end
                n++;
            end
            @(negedge clk);
        end
        if (!finished) chk("fill_timeout", 0, 1);
        rdy_in = 1'b1; flush_in = 1'b0;
        #1;
        chk("after_busy", fill_busy, 0);
        chk("after_update", update, 0);
        chk("after_rd_en", mem_rd_en, 0);
        if (!aborted) chk("held_inst", mem2cache_inst, exp_word);
        else begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk); #1;
                chk("abort_no_update", update, 0);
                chk("abort_idle", fill_busy, 0);
            end
        end
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; fill_req = 1'b1;
        fill_pc = 32'h0000_1004; mem_gnt = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", fill_busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_update", update, 0);
        chk("rst_inst", mem2cache_inst, 0);
        chk("rst_pc", mem2cache_PC, 0);
        chk("rst_is_c", is_c_inst, 0);
        chk("rst_sec", sec_inst_addr, 0);
        @(negedge clk);
        fill_req = 1'b0; mem_gnt = 1'b0; rst_n_in = 1'b1;

        mem_ovr[32'h1004] = 8'h13; mem_ovr[32'h1005] = 8'h05;
        mem_ovr[32'h1006] = 8'hA0; mem_ovr[32'h1007] = 8'h00;
        run_fill(32'h0000_1004, 0, -1, 0, -1);
        chk("basic_inst", mem2cache_inst, 32'h00A0_0513);
        chk("basic_tag", mem2cache_tag, 27'h80);

        mem_ovr[32'h1E] = 8'h05; mem_ovr[32'h1F] = 8'h05;
        mem_ovr[32'h20] = 8'h05; mem_ovr[32'h21] = 8'h45;
        run_fill(32'h0000_001E, 0, -1, 0, -1);

        run_fill(32'h0000_2040, 0, -1, 0, 2);
        run_fill(32'h0000_2044, 0, -1, 0, -1);
        run_fill(32'h0000_3000, 3, -1, 0, -1);
        run_fill(32'h0000_4010, 0, 2, 2, -1);
        run_fill(32'h0000_5000, 0, -1, 0, 5);

        @(negedge clk);
        fill_req = 1'b1; fill_pc = 32'h0000_6000; mem_gnt = 1'b1; flush_in = 1'b1;
        #1 chk("flush_req_mem_req", mem_req, 0);
        @(negedge clk);
        fill_req = 1'b0; mem_gnt = 1'b0; flush_in = 1'b0;
        #1 chk("flush_req_idle", fill_busy, 0);

        for (int k = 0; k < 25; k++) begin
            logic [31:0] rpc;
            int fa;
            rpc = $urandom & 32'hFFFF_FFFE;
            fa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_fill(rpc, $urandom_range(0, 2), $urandom_range(0, 5), $urandom_range(0, 2), fa);
        end

        @(negedge clk);
        fill_req = 1'b1; fill_pc = 32'h0000_7000; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("pre_rst_busy", fill_busy, 1);
        rst_n_in = 1'b0;
        #1;
        chk("async_rst_busy", fill_busy, 0);
        chk("async_rst_mem_req", mem_req, 0);
        chk("async_rst_rd_en", mem_rd_en, 0);
        chk("async_rst_mem_a", mem_a, 0);
        chk("async_rst_inst", mem2cache_inst, 0);
        chk("async_rst_pc", mem2cache_PC, 0);
        @(negedge clk);
        fill_req = 1'b0; rst_n_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #1;
            chk("post_rst_no_update", update, 0);
            chk("post_rst_idle", fill_busy, 0);
        end
        run_fill(32'h0000_7100, 0, -1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_fill.md
ICACHE_FILL -- requirements
Module: icache_fill

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port rdy_in, input, 1, global ready; when low, all state holds.
REQ-004 SHALL have port flush_in, input, 1, pipeline flush; aborts any fill in progress.
REQ-005 SHALL have port fill_req, input, 1, icache miss request.
REQ-006 SHALL have port fill_pc, input, 32, miss PC; bit 0 is always 0.
REQ-007 SHALL have ports mem_req (output, 1) and mem_gnt (input, 1), the memory-bus arbitration pair.
REQ-008 SHALL have ports mem_a (output, 32, byte address), mem_rd_en (output, 1) and mem_din (input, 8, read data).
REQ-009 SHALL have ports update (output, 1), mem2cache_inst (output, 32), mem2cache_idx (output, 4), mem2cache_tag (output, 27) and mem2cache_PC (output, 32), the cache fill.
REQ-010 SHALL have ports is_c_inst (output, 1), sec_inst_addr (output, 32), sec_inst_index (output, 4) and sec_inst_tag (output, 27), the compressed second half.
REQ-011 SHALL have port fill_busy, output, 1; it is high whenever the state is not IDLE.

Function
REQ-012 SHALL implement an FSM with states IDLE, READ and DONE.
REQ-013 IDLE->READ SHALL occur when fill_req && mem_gnt && !flush_in; on that edge it SHALL latch pc_lat=fill_pc and set byte counter cnt=0.
REQ-014 mem_req SHALL be high when (IDLE && fill_req && !flush_in) or in READ, and low otherwise.
REQ-015 In READ, mem_rd_en=1 and mem_a=pc_lat+cnt while cnt<=3; cnt SHALL increment once per edge and saturate at 4.
REQ-016 Memory read latency SHALL be one cycle: the byte addressed in cycle t is captured from mem_din at the end of cycle t+1 into bits [8k+7:8k] for byte k.
REQ-017 After byte 3 is captured, the FSM SHALL enter DONE; update=1 for exactly one cycle, starting 5 cycles after the acceptance edge.
REQ-018 In DONE: mem2cache_inst=assembled word, mem2cache_PC=pc_lat, idx=pc_lat[4:1], tag=pc_lat[31:5].
REQ-019 In DONE: sec_inst_addr=pc_lat+2 (32-bit wrap), sec_inst_index=(pc_lat+2)[4:1], sec_inst_tag=(pc_lat+2)[31:5].
REQ-020 Fill outputs SHALL hold their last values outside DONE; consumers SHALL qualify them only with update.
REQ-021 DONE->IDLE SHALL occur unconditionally on the next edge; a request is never accepted in DONE.
REQ-022 A flush_in during READ SHALL return the FSM to IDLE on that edge; mem_rd_en drops and no update occurs for that fill.
REQ-023 A flush_in in DONE SHALL NOT suppress the update pulse, because the data is valid for that PC.
REQ-024 A flush_in in the same cycle as fill_req SHALL prevent acceptance.
REQ-025 A request in IDLE without mem_gnt SHALL wait in IDLE with mem_req held high.
REQ-026 When rdy_in=0, state, cnt and the captured bytes SHALL hold; mem_rd_en=0 and update=0 for that cycle.

Reset
REQ-027 While rst_n_in=0, the block SHALL be in IDLE with cnt=0, pc_lat=0, the data word 0, and all outputs 0, independent of clk.
REQ-028 Reset asserted mid-fill SHALL abort the fill with no update pulse; after release the block SHALL restart from IDLE.

Configuration
REQ-029 Macro ICACHE_FILL_COMPRESSED_EN defined: is_c_inst=(assembled[1:0]!=2'b11) in DONE and the sec_* fields are driven per REQ-019.
REQ-030 Macro ICACHE_FILL_COMPRESSED_EN undefined: is_c_inst is constant 0, the sec_* outputs are constant 0, and no pc+2 adder exists.

Verification
REQ-031 Reset, then fill_pc=0x0000_1004 with mem_gnt=1 and bytes 13,05,A0,00 -> mem_a 0x1004..0x1007 on 4 consecutive cycles; update 5 cycles later with inst=0x00A0_0513, idx=2, tag=0x80, is_c_inst=0.
REQ-032 (COMPRESSED_EN) fill_pc=0x0000_001E with word 0x4505_0505 -> is_c_inst=1, sec_inst_addr=0x20, sec_inst_index=0, sec_inst_tag=1, idx=15, tag=0.
REQ-033 flush_in pulsed in the 3rd READ cycle -> IDLE on the next cycle, no update; a new request 2 cycles later completes normally.
REQ-034 fill_req with mem_gnt=0 for 3 cycles, then 1 -> mem_req high throughout, mem_rd_en low until the grant, then the fill completes.
REQ-035 rdy_in low for 2 cycles mid-READ -> mem_a frozen, update delayed by exactly 2 cycles, data word correct.
REQ-036 rst_n_in pulsed low mid-READ -> outputs 0 immediately with no clock edge, and no update afterwards.
